// File: rtl/sd_sec_read_arbiter.sv
// sd_sec_read_arbiter: round-robin sharing of the SD sector-read port between two requesters
module sd_sec_read_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sd_init_done,
  input  logic              req0_read,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic [7:0]        req0_data,
  output logic              req0_data_valid,
  output logic              req0_end,
  output logic              req0_timeout,
  input  logic              req1_read,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic [7:0]        req1_data,
  output logic              req1_data_valid,
  output logic              req1_end,
  output logic              req1_timeout,
  output logic              sd_sec_read,
  output logic [ADDR_W-1:0] sd_sec_read_addr,
  input  logic [7:0]        sd_sec_read_data,
  input  logic              sd_sec_read_data_valid,
  input  logic              sd_sec_read_end,
  output logic              busy,
  output logic              grant
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t            state_q, state_d;
  logic              sd_sec_read_q, sd_sec_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              winner;
  logic              route0, route1;
  // next-state: arbitrate in IDLE, watch for end or watchdog expiry in BUSY, one-cycle RELEASE
  always_comb begin
    state_d       = state_q;
    sd_sec_read_d = sd_sec_read_q;
    addr_d        = addr_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
    winner        = (req0_read && req1_read) ? ~last_grant_q : req1_read;
    case (state_q)
      IDLE: if (sd_init_done && (req0_read || req1_read)) begin
        grant_d       = winner;
        last_grant_d  = winner;
        addr_d        = winner ? req1_addr : req0_addr;
        sd_sec_read_d = 1'b1;
        cnt_d         = '0;
        state_d       = BUSY;
      end
      BUSY: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        if (sd_sec_read_end || cnt_q >= CNT_LAST) begin
          sd_sec_read_d = 1'b0;
          timeout_d     = ~sd_sec_read_end;
          state_d       = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register, asynchronously cleared so a mid-transfer reset drops everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sd_sec_read_q <= 1'b0;
      addr_q        <= '0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sd_sec_read_q <= sd_sec_read_d;
      addr_q        <= addr_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end
  assign route0           = (state_q == BUSY) && !grant_q;
  assign route1           = (state_q == BUSY) && grant_q;
  assign req0_data        = route0 ? sd_sec_read_data : 8'd0;
  assign req0_data_valid  = route0 && sd_sec_read_data_valid;
  assign req0_end         = route0 && sd_sec_read_end;
  assign req0_timeout     = timeout_q && !grant_q;
  assign req1_data        = route1 ? sd_sec_read_data : 8'd0;
  assign req1_data_valid  = route1 && sd_sec_read_data_valid;
  assign req1_end         = route1 && sd_sec_read_end;
  assign req1_timeout     = timeout_q && grant_q;
  assign sd_sec_read      = sd_sec_read_q;
  assign sd_sec_read_addr = addr_q;
  assign busy             = state_q != IDLE;
  assign grant            = grant_q;
endmodule
